// File: rtl/fu_scoreboard.sv
// Issue/retire scoreboard: per-FU occupancy, per-register pending writes, single write-port arbitration.
// Optional same-cycle retire bypass into issue_ready: define SB_RETIRE_BYPASS_EN.
module fu_scoreboard #(
  parameter int NUM_FU = 5,
  parameter int FU_W   = 3,
  parameter int REG_AW = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic [FU_W-1:0]        issue_fu,
  input  logic [REG_AW-1:0]      issue_rd,
  input  logic [REG_AW-1:0]      issue_rs1,
  input  logic [REG_AW-1:0]      issue_rs2,
  input  logic                   issue_use_rs1,
  input  logic                   issue_use_rs2,
  input  logic                   issue_wr_rd,
  output logic [NUM_FU-1:0]      fu_en,
  input  logic [NUM_FU-1:0]      fu_done,
  output logic                   wb_valid,
  output logic                   wb_we,
  output logic [FU_W-1:0]        wb_fu,
  output logic [REG_AW-1:0]      wb_rd,
  output logic [NUM_FU-1:0]      fu_busy,
  output logic [(2**REG_AW)-1:0] reg_pend,
  output logic                   idle
);

  localparam int NREG = 2**REG_AW;
  localparam logic [FU_W:0] NFU = (FU_W+1)'(NUM_FU);

  logic [NUM_FU-1:0] busy_q, busy_d;
  logic [NUM_FU-1:0] dpend_q, dpend_d;
  logic [NUM_FU-1:0] we_q, we_d;
  logic [NUM_FU-1:0][REG_AW-1:0] rd_q, rd_d;
  logic [NREG-1:0] pend_q, pend_d;

  logic [NUM_FU-1:0] ret_oh;
  logic [NUM_FU-1:0] busy_ck;
  logic [NREG-1:0]   pend_ck;
  logic fu_ok, busy_hit, fire;
  logic rs1_haz, rs2_haz, rd_haz;

  // Lowest set bit of done_pend is the retiring FU.
  assign ret_oh   = dpend_q & (~dpend_q + NUM_FU'(1));
  assign wb_valid = |dpend_q;

  always_comb begin
    wb_fu = '0;
    wb_rd = '0;
    wb_we = 1'b0;
    for (int i = NUM_FU-1; i >= 0; i--) begin
      if (dpend_q[i]) begin
        wb_fu = FU_W'(i);
        wb_rd = rd_q[i];
        wb_we = we_q[i];
      end
    end
  end

`ifdef SB_RETIRE_BYPASS_EN
  assign busy_ck = busy_q & ~ret_oh;
  always_comb begin
    pend_ck = pend_q;
    if (wb_we) pend_ck[wb_rd] = 1'b0;
  end
`else
  assign busy_ck = busy_q;
  assign pend_ck = pend_q;
`endif

  assign fu_ok = {1'b0, issue_fu} < NFU;

  always_comb begin
    busy_hit = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (issue_fu == FU_W'(i)) busy_hit = busy_ck[i];
    end
  end

  assign rs1_haz = issue_use_rs1 & (|issue_rs1) & pend_ck[issue_rs1];
  assign rs2_haz = issue_use_rs2 & (|issue_rs2) & pend_ck[issue_rs2];
  assign rd_haz  = issue_wr_rd & (|issue_rd) & pend_ck[issue_rd];

  assign issue_ready = fu_ok & ~busy_hit & ~rs1_haz & ~rs2_haz & ~rd_haz;
  assign fire        = issue_valid & issue_ready;

  always_comb begin
    fu_en = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      fu_en[i] = fire & (issue_fu == FU_W'(i));
    end
  end

  // Retire clears first, then completion and issue, so issue sets win.
  always_comb begin
    busy_d  = busy_q;
    dpend_d = dpend_q;
    we_d    = we_q;
    rd_d    = rd_q;
    pend_d  = pend_q;
    busy_d  = busy_d & ~ret_oh;
    dpend_d = dpend_d & ~ret_oh;
    if (wb_we) pend_d[wb_rd] = 1'b0;
    dpend_d = dpend_d | (fu_done & busy_q & ~dpend_q);
    for (int i = 0; i < NUM_FU; i++) begin
      if (fu_en[i]) begin
        busy_d[i] = 1'b1;
        rd_d[i]   = issue_rd;
        we_d[i]   = issue_wr_rd & (|issue_rd);
      end
    end
    if (fire & issue_wr_rd & (|issue_rd)) pend_d[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      dpend_q <= '0;
      we_q    <= '0;
      rd_q    <= '0;
      pend_q  <= '0;
    end else begin
      busy_q  <= busy_d;
      dpend_q <= dpend_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      pend_q  <= pend_d;
    end
  end

  assign fu_busy  = busy_q;
  assign reg_pend = pend_q;
  assign idle     = ~|busy_q;

endmodule
